readout_packet_builder: RTL and testbench
=========================================

// Module: readout_packet_builder
// PURPOSE
// - Consumer end of the readout output FIFO: drains 32-bit merged TDC words (standard-mode FIFO, dout valid 1 cycle after rd_en).
// - Buffers up to MAX_WORDS words, then emits a framed packet (header, payload, trailer) on a ready/valid stream to the Ethernet TX path.
// - Packets close on buffer full, on idle timeout, or on enable drop; empty packets are never sent.
// PARAMETERS
// - MAX_WORDS   16       payload words per packet, 1..255
// - TIMEOUT     1024     cycles from first captured word until forced close, >=1
// - HEADER_TAG  16'hE7C0 header word [31:16]
// - TRAILER_TAG 16'h3C5A trailer word [31:16]
// PORTS
// - clk160       in  1  sole clock; all logic on rising edge
// - reset_n      in  1  asynchronous, active-low reset
// - enable       in  1  permits new FIFO reads and packet starts
// - fifo_dout    in  32 output FIFO data
// - fifo_empty   in  1  output FIFO empty
// - fifo_rd_en   out 1  output FIFO read enable
// - tx_data      out 32 stream word
// - tx_valid     out 1  tx_data valid
// - tx_ready     in  1  downstream accepts word when tx_valid & tx_ready
// - tx_last      out 1  marks trailer word
// - pkt_count    out 16 packets completed (trailer accepted), wraps 0xFFFF->0
// - busy         out 1  high in any state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0, buffer count 0, seq 0, timer 0, state IDLE; applies immediately, mid-packet data discarded, no partial trailer.
// - States: IDLE -> FILL -> HDR -> PAY -> [CHK] -> TRL -> IDLE.
// - IDLE: enable & ~fifo_empty -> FILL next cycle.
// - FILL: fifo_rd_en = enable & ~fifo_empty & (fill_cnt + rd_pend < MAX_WORDS); rd_pend = registered fifo_rd_en.
// - Capture: when rd_pend=1, fifo_dout written to buf[fill_cnt], fill_cnt++; back-to-back reads give 1 word/cycle.
// - Timer: cleared in IDLE, starts at first capture, +1 per FILL cycle, saturates at TIMEOUT.
// - Leave FILL for HDR when rd_pend=0 and fill_cnt>0 and any of: fill_cnt==MAX_WORDS; timer==TIMEOUT; enable=0.
// - enable=0 in FILL with fill_cnt=0 and rd_pend=0 -> IDLE. fifo_rd_en is 0 in every state but FILL.
// - HDR: tx_data = {HEADER_TAG, seq[7:0], fill_cnt[7:0]}.
// - PAY: buf[0..fill_cnt-1] in capture order, one per handshake.
// - TRL: tx_data = {TRAILER_TAG, 8'h00, seq}, tx_last=1; on handshake seq++ (wraps 0xFF->0x00), pkt_count++, fill_cnt=0 -> IDLE.
// - Stream rule: tx_valid high throughout HDR/PAY/[CHK]/TRL; tx_data/tx_last held stable while tx_valid & ~tx_ready; advance only on handshake.
// - tx_valid, tx_last registered; tx_last never high outside TRL.
// - enable changes outside FILL/IDLE have no effect on the packet in flight.
// CONFIGURATION
// - Macro PKT_CHECKSUM_EN defined: CHK state between PAY and TRL emits one word = XOR of header word and all payload words.
// - Undefined: no CHK state; PAY goes directly to TRL; packet length = fill_cnt+2.
// TESTING
// - 16 words 0x1..0x10 preloaded, enable=1, tx_ready=1 -> 0xE7C00010, 0x1..0x10, 0x3C5A0000 with tx_last; pkt_count=1.
// - 3 words then FIFO empty -> header 0xE7C00003 exactly TIMEOUT cycles after first capture; fifo_rd_en=0 during HDR..TRL.
// - tx_ready low 50 cycles at payload word 5 -> tx_data constant; no word lost or duplicated.
// - Hold enable=0 with FIFO nonempty -> fifo_rd_en stays 0, busy=0; drop enable after 4 captures -> packet n=4 emitted.
// - 256 single-word packets -> 256th header seq=0xFF, next seq=0x00; pkt_count=0x0100.
// - reset_n low during PAY -> all outputs 0 immediately; first post-reset header seq=0x00.
// - PKT_CHECKSUM_EN, words 0x1,0x2,0x3 -> check word 0xE7C00003^0x1^0x2^0x3=0xE7C00003 before trailer.

Source files
------------

// File: rtl/readout_packet_builder.sv
// Drains merged TDC words from the readout FIFO and frames them into header/payload/trailer packets.
// Define PKT_CHECKSUM_EN to insert an XOR check word between the payload and the trailer.
module readout_packet_builder #(
    parameter int          MAX_WORDS   = 16,
    parameter int          TIMEOUT     = 1024,
    parameter logic [15:0] HEADER_TAG  = 16'hE7C0,
    parameter logic [15:0] TRAILER_TAG = 16'h3C5A
) (
    input  logic        clk160,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic [15:0] pkt_count,
    output logic        busy
);

    localparam int             IW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [8:0]     MAX_CNT   = 9'(MAX_WORDS);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HDR,
        S_PAY,
`ifdef PKT_CHECKSUM_EN
        S_CHK,
`endif
        S_TRL
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      fill_cnt_q, fill_cnt_d;
    logic [7:0]      rd_idx_q, rd_idx_d;
    logic            rd_pend_q, rd_pend_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      seq_q, seq_d;
    logic [15:0]     pkt_count_q, pkt_count_d;
    logic [31:0]     tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            tx_last_q, tx_last_d;
`ifdef PKT_CHECKSUM_EN
    logic [31:0]     csum_q, csum_d;
`endif
    logic [31:0]     buf_q [MAX_WORDS];
    logic            buf_we;
    logic            rd_en;
    logic            handshake;
    logic [31:0]     hdr_word;
    logic [31:0]     trl_word;
    logic [31:0]     buf_rd;

    // Reads stop once the timer saturates so that no word is in flight when the packet closes.
    assign rd_en = (state_q == S_FILL) && enable && !fifo_empty
                   && (({1'b0, fill_cnt_q} + 9'(rd_pend_q)) < MAX_CNT)
                   && (timer_q != TIMER_MAX);

    assign handshake = tx_valid_q && tx_ready;
    assign hdr_word  = {HEADER_TAG, seq_q, fill_cnt_q};
    assign trl_word  = {TRAILER_TAG, 8'h00, seq_q};
    assign buf_rd    = buf_q[rd_idx_q[IW-1:0]];

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        rd_idx_d    = rd_idx_q;
        rd_pend_d   = rd_en;
        timer_d     = timer_q;
        seq_d       = seq_q;
        pkt_count_d = pkt_count_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        buf_we      = 1'b0;
`ifdef PKT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (enable && !fifo_empty) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (rd_pend_q) begin
                    buf_we     = 1'b1;
                    fill_cnt_d = fill_cnt_q + 8'd1;
                end
                // The timer runs from the first captured word until it saturates.
                if ((fill_cnt_q != 8'd0 || rd_pend_q) && timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
                if (!rd_pend_q) begin
                    if (fill_cnt_q != 8'd0 && ({1'b0, fill_cnt_q} == MAX_CNT
                                               || timer_q == TIMER_MAX || !enable)) begin
                        state_d    = S_HDR;
                        tx_valid_d = 1'b1;
                        tx_data_d  = hdr_word;
`ifdef PKT_CHECKSUM_EN
                        csum_d     = hdr_word;
`endif
                    end else if (fill_cnt_q == 8'd0 && !enable) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HDR: begin
                if (handshake) begin
                    state_d   = S_PAY;
                    tx_data_d = buf_q[0];
                    rd_idx_d  = 8'd1;
`ifdef PKT_CHECKSUM_EN
                    csum_d    = csum_q ^ buf_q[0];
`endif
                end
            end
            S_PAY: begin
                if (handshake) begin
                    if (rd_idx_q == fill_cnt_q) begin
`ifdef PKT_CHECKSUM_EN
                        state_d   = S_CHK;
                        tx_data_d = csum_q;
`else
                        state_d   = S_TRL;
                        tx_data_d = trl_word;
                        tx_last_d = 1'b1;
`endif
                    end else begin
                        tx_data_d = buf_rd;
                        rd_idx_d  = rd_idx_q + 8'd1;
`ifdef PKT_CHECKSUM_EN
                        csum_d    = csum_q ^ buf_rd;
`endif
                    end
                end
            end
`ifdef PKT_CHECKSUM_EN
            S_CHK: begin
                if (handshake) begin
                    state_d   = S_TRL;
                    tx_data_d = trl_word;
                    tx_last_d = 1'b1;
                end
            end
`endif
            S_TRL: begin
                if (handshake) begin
                    state_d     = S_IDLE;
                    tx_valid_d  = 1'b0;
                    tx_last_d   = 1'b0;
                    tx_data_d   = '0;
                    seq_d       = seq_q + 8'd1;
                    pkt_count_d = pkt_count_q + 16'd1;
                    fill_cnt_d  = 8'd0;
                    rd_idx_d    = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            fill_cnt_q  <= 8'd0;
            rd_idx_q    <= 8'd0;
            rd_pend_q   <= 1'b0;
            timer_q     <= '0;
            seq_q       <= 8'd0;
            pkt_count_q <= 16'd0;
            tx_data_q   <= 32'd0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum_q      <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            rd_idx_q    <= rd_idx_d;
            rd_pend_q   <= rd_pend_d;
            timer_q     <= timer_d;
            seq_q       <= seq_d;
            pkt_count_q <= pkt_count_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
`ifdef PKT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Payload storage carries no reset; only words below fill_cnt are ever read.
    always_ff @(posedge clk160) begin
        if (buf_we) begin
            buf_q[fill_cnt_q[IW-1:0]] <= fifo_dout;
        end
    end

    assign fifo_rd_en = rd_en;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_last    = tx_last_q;
    assign pkt_count  = pkt_count_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_readout_packet_builder.sv
// Self-checking bench for readout_packet_builder: FIFO model feeding the DUT and a packet-level scoreboard on the stream.
`timescale 1ns/1ps
module tb_readout_packet_builder;

    localparam int MAX_WORDS = 16;
    localparam int TIMEOUT   = 1024;

    typedef struct {
        logic [31:0] dat;
        logic        is_last;
        logic        is_hdr;
    } exp_t;

    logic        clk160 = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] fifo_dout = 32'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_last;
    logic [15:0] pkt_count;
    logic        busy;

    logic [31:0] fifo_q[$];
    logic [31:0] src_words[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          exp_seq = 0;
    int          exp_pkts = 0;
    int          hs_count = 0;
    int          hs_base = 0;
    logic [31:0] last_hdr = 32'd0;
    bit          rand_ready = 1'b0;

    always #5 clk160 = ~clk160;

    readout_packet_builder #(
        .MAX_WORDS  (MAX_WORDS),
        .TIMEOUT    (TIMEOUT),
        .HEADER_TAG (16'hE7C0),
        .TRAILER_TAG(16'h3C5A)
    ) dut (
        .clk160    (clk160),
        .reset_n   (reset_n),
        .enable    (enable),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    // Standard-mode FIFO: data appears the cycle after rd_en, empty flag is registered.
    always @(posedge clk160) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_dout <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w);
        fifo_q.push_back(w);
        src_words.push_back(w);
    endtask

    // Words queued since the last call form packets of at most MAX_WORDS, in order.
    task automatic expectChunks();
        int          n;
        logic [31:0] hdr;
        logic [31:0] csum;
        logic [31:0] w;
        while (src_words.size() > 0) begin
            n    = (src_words.size() > MAX_WORDS) ? MAX_WORDS : src_words.size();
            hdr  = {16'hE7C0, 8'(exp_seq), 8'(n)};
            csum = hdr;
            exp_q.push_back('{dat: hdr, is_last: 1'b0, is_hdr: 1'b1});
            for (int k = 0; k < n; k++) begin
                w    = src_words.pop_front();
                csum = csum ^ w;
                exp_q.push_back('{dat: w, is_last: 1'b0, is_hdr: 1'b0});
            end
`ifdef PKT_CHECKSUM_EN
            exp_q.push_back('{dat: csum, is_last: 1'b0, is_hdr: 1'b0});
`endif
            exp_q.push_back('{dat: {16'h3C5A, 8'h00, 8'(exp_seq)}, is_last: 1'b1, is_hdr: 1'b0});
            exp_seq  = (exp_seq + 1) % 256;
            exp_pkts = (exp_pkts + 1) % 65536;
        end
    endtask

    task automatic tick();
        @(posedge clk160);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic runUntilDone(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, (exp_q.size() == 0 && !busy), 1);
        checkOutput({tag, "_pktCount"}, pkt_count, exp_pkts);
    endtask

    task automatic waitFifoDrained(input int budget, input string tag);
        int n = 0;
        while (fifo_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, fifo_q.size(), 0);
        tick();
        tick();
    endtask

    // Whatever is on the stream must be the oldest outstanding expected word, also while stalled.
    always @(negedge clk160) begin
        if (reset_n) begin
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spuriousValid", tx_valid, 0);
                end else begin
                    checkOutput("txData", tx_data, exp_q[0].dat);
                    checkOutput("txLast", tx_last, exp_q[0].is_last);
                    if (tx_ready) begin
                        mon_e = exp_q.pop_front();
                        hs_count++;
                        if (mon_e.is_hdr) last_hdr = tx_data;
                    end
                end
            end else begin
                checkOutput("lastWithoutValid", tx_last, 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        int c_rd;
        int c_val;
        int n;
        int nb;

        tx_ready = 1'b1;
        repeat (3) @(posedge clk160);
        #1;
        checkOutput("rstTxValid", tx_valid, 0);
        checkOutput("rstTxLast", tx_last, 0);
        checkOutput("rstTxData", tx_data, 0);
        checkOutput("rstPktCount", pkt_count, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstRdEn", fifo_rd_en, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] full packet of 16 words");
        for (int i = 1; i <= 16; i++) applyStimulus(32'(i));
        expectChunks();
        enable = 1'b1;
        runUntilDone(300, "fullPkt");
        checkOutput("fullPktCount", pkt_count, 1);
        enable = 1'b0;

        $display("[TB] enable held low, then dropped after 4 captures");
        for (int i = 0; i < 4; i++) applyStimulus($urandom);
        expectChunks();
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("holdRdEn", fifo_rd_en, 0);
            checkOutput("holdBusy", busy, 0);
        end
        enable = 1'b1;
        waitFifoDrained(50, "dropDrain");
        enable = 1'b0;
        runUntilDone(100, "dropPkt");

        $display("[TB] timeout close with 3 words");
        for (int i = 0; i < 3; i++) applyStimulus($urandom);
        expectChunks();
        enable = 1'b1;
        c = 0; c_rd = -1; c_val = -1;
        while (c_val < 0 && c < TIMEOUT + 100) begin
            tick();
            c++;
            if (c_rd < 0 && fifo_rd_en) c_rd = c;
            if (tx_valid) c_val = c;
        end
        checkOutput("timeoutLatency", c_val - c_rd, TIMEOUT + 2);
        applyStimulus($urandom);
        rand_ready = 1'b1;
        n = 0;
        while (pkt_count != 16'd3 && n < 500) begin
            if (tx_valid) checkOutput("rdEnDuringTx", fifo_rd_en, 0);
            tick();
            n++;
        end
        checkOutput("timeoutPktDone", pkt_count, 3);
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        expectChunks();
        waitFifoDrained(50, "tailDrain");
        enable = 1'b0;
        runUntilDone(100, "tailPkt");

        $display("[TB] 50-cycle stall on payload word 5");
        for (int i = 0; i < 16; i++) applyStimulus($urandom);
        expectChunks();
        hs_base = hs_count;
        enable = 1'b1;
        n = 0;
        while (!(tx_valid && (hs_count - hs_base) == 5) && n < 300) begin
            tick();
            n++;
        end
        checkOutput("stallReach", hs_count - hs_base, 5);
        tx_ready = 1'b0;
        repeat (50) tick();
        checkOutput("stallNoAccept", hs_count - hs_base, 5);
        checkOutput("stallValid", tx_valid, 1);
        tx_ready = 1'b1;
        runUntilDone(200, "stallPkt");
        enable = 1'b0;

        $display("[TB] randomized batches with random backpressure");
        for (int b = 0; b < 4; b++) begin
            nb = $urandom_range(1, 40);
            for (int i = 0; i < nb; i++) applyStimulus($urandom);
            expectChunks();
            enable = 1'b1;
            rand_ready = 1'b1;
            runUntilDone(3500, "randBatch");
            rand_ready = 1'b0;
            tx_ready = 1'b1;
            enable = 1'b0;
        end

        $display("[TB] asynchronous reset during payload");
        for (int i = 0; i < 16; i++) applyStimulus($urandom);
        expectChunks();
        hs_base = hs_count;
        enable = 1'b1;
        n = 0;
        while ((hs_count - hs_base) < 3 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("reachPay", hs_count - hs_base, 3);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstTxValid", tx_valid, 0);
        checkOutput("midRstTxLast", tx_last, 0);
        checkOutput("midRstTxData", tx_data, 0);
        checkOutput("midRstPktCount", pkt_count, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstRdEn", fifo_rd_en, 0);
        exp_q.delete();
        src_words.delete();
        fifo_q.delete();
        exp_seq = 0;
        exp_pkts = 0;
        enable = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] 257 single-word packets");
        for (int i = 0; i < 257; i++) begin
            applyStimulus($urandom);
            expectChunks();
            enable = 1'b1;
            waitFifoDrained(20, "singleDrain");
            enable = 1'b0;
            runUntilDone(40, "singlePkt");
            if (i == 255) begin
                checkOutput("seqFFHdr", last_hdr, 32'hE7C0FF01);
                checkOutput("pktCount256", pkt_count, 16'h0100);
            end
        end
        checkOutput("seqWrapHdr", last_hdr, 32'hE7C00001);
        checkOutput("pktCount257", pkt_count, 16'h0101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
